ntt_job_sequencer: RTL and testbench
====================================

NTT_JOB_SEQUENCER -- requirements
Module: ntt_job_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: number of command FIFO entries, a power of two and at least 2.
REQ-002 The block SHALL have parameter MAX_MOD_IDX, default 59: highest legal modulus index.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in cycles.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  host command valid.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_mod_idx  input  6  modulus index for the job.
REQ-009 cmd_tag  input  4  host job tag, returned in the response.
REQ-010 core_start  output  1  one-cycle start pulse to the NTT controller.
REQ-011 core_mod_idx  output  6  modulus index driven to the NTT controller.
REQ-012 core_done  input  1  NTT controller idle level; high when idle.
REQ-013 rsp_valid  output  1  job response valid.
REQ-014 rsp_ready  input  1  host accepts the response.
REQ-015 rsp_tag  output  4  tag of the completed job.
REQ-016 rsp_error  output  1  job was rejected or timed out.
REQ-017 busy  output  1  FSM not in IDLE, or FIFO not empty.
REQ-018 jobs_done_count  output  16  count of successful jobs; saturates at 16'hFFFF.

Function
REQ-019 Commands SHALL be pushed into a FIFO of {tag, mod_idx} entries; cmd_ready = FIFO not full, with no bypass path.
REQ-020 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK, RUN and RESPOND.
REQ-021 IDLE: when the FIFO is non-empty and core_done=1, the head entry SHALL be popped into a job register and the FSM SHALL move to LAUNCH; core_mod_idx SHALL take the new mod_idx in that same cycle.
REQ-022 IDLE, out-of-range head (mod_idx > MAX_MOD_IDX): the entry SHALL be popped and the FSM SHALL go directly to RESPOND with rsp_error=1; core_start SHALL not be asserted.
REQ-023 LAUNCH: core_start=1 for exactly one cycle; the FSM SHALL then move to WAIT_ACK.
REQ-024 WAIT_ACK: the FSM SHALL wait for core_done=0, then move to RUN.
REQ-025 RUN: the FSM SHALL wait for core_done=1, then move to RESPOND with rsp_error=0 and jobs_done_count increment, saturating.
REQ-026 core_mod_idx SHALL be held stable from the IDLE pop through the end of RESPOND and SHALL keep its last value while in IDLE.
REQ-027 RESPOND: rsp_valid=1 with rsp_tag and rsp_error stable until rsp_ready=1; in the handshake cycle the FSM SHALL return to IDLE.
REQ-028 A new launch SHALL occur no earlier than the cycle after the response handshake.
REQ-029 Command push SHALL remain permitted in every FSM state.
REQ-030 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 On reset: FSM=IDLE, FIFO emptied, cmd_ready=1, core_start=0, core_mod_idx=0, rsp_valid=0, rsp_tag=0, rsp_error=0, busy=0, jobs_done_count=0, watchdog=0.
REQ-033 Reset asserted mid-job SHALL discard the job with no response.
REQ-034 After such a reset, the first launch SHALL still wait for core_done=1.

Configuration
REQ-035 When macro NTT_JOB_SEQUENCER_TIMEOUT_EN is defined, a watchdog SHALL count cycles spent in WAIT_ACK plus RUN, cleared on entry to LAUNCH.
REQ-036 With the macro defined, reaching TIMEOUT_CYCLES SHALL force RESPOND with rsp_error=1 and no counter increment; the core is not aborted.
REQ-037 Without the macro, no watchdog logic SHALL exist and WAIT_ACK/RUN SHALL wait indefinitely.

Structure
REQ-038 Package ntt_seq_pkg SHALL hold the state enum, the command struct {tag, mod_idx}, and the widths MOD_IDX_W=6, TAG_W=4 and CNT_W=16.
REQ-039 The FIFO SHALL be sub-module ntt_seq_fifo, parameterised by depth and data width.

Verification
REQ-040 Single job mod_idx=5, tag=3; the core model drops done 2 cycles after start and raises it 100 cycles later -> one core_start pulse, core_mod_idx=5 stable throughout, rsp_tag=3, rsp_error=0, jobs_done_count=1.
REQ-041 Push 4 jobs back-to-back with the core stalled -> cmd_ready=0 after the 4th; cmd_ready returns to 1 the cycle after the first pop; responses arrive in tag order 0,1,2,3.
REQ-042 mod_idx=60 -> no core_start, rsp_error=1, jobs_done_count unchanged.
REQ-043 rsp_ready held low for 10 cycles -> rsp_valid and rsp_tag stable for all 10 cycles; no second core_start during the hold.
REQ-044 Reset in RUN with 2 jobs queued -> all outputs at reset values next cycle; no response for the lost jobs.
REQ-045 With NTT_JOB_SEQUENCER_TIMEOUT_EN and TIMEOUT_CYCLES=50, core_done held at 0 -> rsp_error=1 after 50 cycles; the next launch waits for core_done=1.

Source files
------------

// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg
// Shared types and widths for the NTT job sequencer:
//   - MOD_IDX_W / TAG_W / CNT_W : field widths of the job command and counter
//   - state_t                   : sequencer FSM encoding
//   - cmd_t                     : queued command {tag, mod_idx}
//   - sat_inc()                 : saturating increment for the jobs counter
package ntt_seq_pkg;

    localparam int MOD_IDX_W = 6;
    localparam int TAG_W     = 4;
    localparam int CNT_W     = 16;
    localparam int CMD_W     = TAG_W + MOD_IDX_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        RESPOND  = 3'd4
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [MOD_IDX_W-1:0] mod_idx;
    } cmd_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/ntt_seq_fifo.sv
// ntt_seq_fifo
// Synchronous command FIFO with registered occupancy.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data   : write request; ignored while full (no bypass)
//   pop, pop_data     : read request; pop_data shows the head entry
//   full, empty       : occupancy flags
module ntt_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == (PTR_W+1)'(0));
    assign pop_data = mem[rd_ptr];

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count is
    // unchanged when a push and a pop land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ntt_job_sequencer.sv
// ntt_job_sequencer
// Queues host NTT jobs, launches them one at a time on the NTT controller
// and returns a tagged response per job.
// Optional feature: define NTT_JOB_SEQUENCER_TIMEOUT_EN to add a watchdog that
// fails a job (rsp_error=1) after TIMEOUT_CYCLES cycles in WAIT_ACK+RUN.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_mod_idx/cmd_tag : host command (into FIFO)
//   core_start/core_mod_idx/core_done  : NTT controller launch interface
//   rsp_valid/rsp_ready/rsp_tag/rsp_error   : job response to host
//   busy                               : FSM active or commands pending
//   jobs_done_count                    : saturating count of successful jobs
module ntt_job_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_MOD_IDX    = 59,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MOD_IDX_W-1:0] cmd_mod_idx,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic                 core_start,
    output logic [MOD_IDX_W-1:0] core_mod_idx,
    input  logic                 core_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [CNT_W-1:0]     jobs_done_count
);

    state_t state;
    state_t next_state;

    cmd_t       cmd_in;
    cmd_t       head;
    logic [CMD_W-1:0] head_raw;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       head_bad;
    logic       load_core;
    logic       enter_respond;
    logic       rsp_error_next;
    logic       count_inc;
    logic       wd_expire;

    assign cmd_in.tag     = cmd_tag;
    assign cmd_in.mod_idx = cmd_mod_idx;
    assign head           = cmd_t'(head_raw);
    assign head_bad       = (int'(head.mod_idx) > MAX_MOD_IDX);
    assign cmd_ready      = !fifo_full;
    assign busy           = (state != IDLE) || !fifo_empty;

    ntt_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef NTT_JOB_SEQUENCER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count;

    // Fires on the last allowed cycle so RESPOND is entered once
    // TIMEOUT_CYCLES cycles have been spent in WAIT_ACK plus RUN.
    assign wd_expire = ((state == WAIT_ACK) || (state == RUN)) &&
                       (int'(wd_count) >= (TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared when a launch is taken, counts WAIT_ACK/RUN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count <= '0;
        end else if (load_core) begin
            wd_count <= '0;
        end else if ((state == WAIT_ACK) || (state == RUN)) begin
            wd_count <= wd_count + WD_W'(1);
        end else begin
            wd_count <= wd_count;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state     = state;
        fifo_pop       = 1'b0;
        load_core      = 1'b0;
        enter_respond  = 1'b0;
        rsp_error_next = 1'b0;
        count_inc      = 1'b0;
        case (state)
            IDLE: begin
                // Illegal indices are rejected without waiting for the core.
                if (!fifo_empty && head_bad) begin
                    fifo_pop       = 1'b1;
                    enter_respond  = 1'b1;
                    rsp_error_next = 1'b1;
                    next_state     = RESPOND;
                end else if (!fifo_empty && core_done) begin
                    fifo_pop   = 1'b1;
                    load_core  = 1'b1;
                    next_state = LAUNCH;
                end else begin
                    next_state = IDLE;
                end
            end
            LAUNCH: begin
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!core_done) begin
                    next_state = RUN;
                end else if (wd_expire) begin
                    enter_respond  = 1'b1;
                    rsp_error_next = 1'b1;
                    next_state     = RESPOND;
                end else begin
                    next_state = WAIT_ACK;
                end
            end
            RUN: begin
                // A real completion wins over a coincident watchdog expiry.
                if (core_done) begin
                    enter_respond  = 1'b1;
                    rsp_error_next = 1'b0;
                    count_inc      = 1'b1;
                    next_state     = RESPOND;
                end else if (wd_expire) begin
                    enter_respond  = 1'b1;
                    rsp_error_next = 1'b1;
                    next_state     = RESPOND;
                end else begin
                    next_state = RUN;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = RESPOND;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and job register. core_start and rsp_valid are
    // decoded from next_state so they line up with LAUNCH / RESPOND.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_start      <= 1'b0;
            rsp_valid       <= 1'b0;
            core_mod_idx    <= '0;
            rsp_tag         <= '0;
            rsp_error       <= 1'b0;
            jobs_done_count <= '0;
        end else begin
            core_start <= (next_state == LAUNCH);
            rsp_valid  <= (next_state == RESPOND);
            if (fifo_pop) begin
                rsp_tag <= head.tag;
            end
            // Rejected indices are never driven to the core.
            if (load_core) begin
                core_mod_idx <= head.mod_idx;
            end
            if (enter_respond) begin
                rsp_error <= rsp_error_next;
            end
            if (count_inc) begin
                jobs_done_count <= sat_inc(jobs_done_count);
            end
        end
    end

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// tb_ntt_job_sequencer
// Directed bench with a response scoreboard: stimulus pushes the expected
// {error, tag} of every command; a monitor pops and compares at each
// response handshake. A simple core model answers core_start pulses.
module tb_ntt_job_sequencer;

`ifdef NTT_JOB_SEQUENCER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_mod_idx;
    logic [3:0]  cmd_tag;
    logic        core_start;
    logic [5:0]  core_mod_idx;
    logic        core_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_tag;
    logic        rsp_error;
    logic        busy;
    logic [15:0] jobs_done_count;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];     // {error, tag}
    logic [5:0] launch_q[$];  // expected core_mod_idx per launch

    // core model controls
    logic core_manual       = 1'b0;
    logic core_manual_level = 1'b1;
    int   drop_delay        = 2;
    int   run_len           = 100;
    int   start_count       = 0;

    ntt_job_sequencer #(
        .FIFO_DEPTH     (4),
        .MAX_MOD_IDX    (59),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mod_idx     (cmd_mod_idx),
        .cmd_tag         (cmd_tag),
        .core_start      (core_start),
        .core_mod_idx    (core_mod_idx),
        .core_done       (core_done),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tag         (rsp_tag),
        .rsp_error       (rsp_error),
        .busy            (busy),
        .jobs_done_count (jobs_done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Core model: drops done drop_delay cycles after a start, raises it run_len later.
    initial begin
        int phase = 0;
        int cnt   = 0;
        core_done = 1'b1;
        forever begin
            @(negedge clk);
            if (core_manual) begin
                core_done = core_manual_level;
                phase     = 0;
            end else if (phase == 0) begin
                if (core_start) begin
                    cnt   = drop_delay;
                    phase = 1;
                end
            end else if (phase == 1) begin
                cnt--;
                if (cnt <= 0) begin
                    core_done = 1'b0;
                    cnt       = run_len;
                    phase     = 2;
                end
            end else begin
                cnt--;
                if (cnt <= 0) begin
                    core_done = 1'b1;
                    phase     = 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       job_active = 1'b0;
        logic       mod_moved  = 1'b0;
        logic [5:0] launch_mod = 6'd0;
        logic [5:0] exp_mod;
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                job_active = 1'b0;
            end else begin
                if (core_start) begin
                    start_count++;
                    if (launch_q.size() == 0) begin
                        chk("launch_unexpected", 0, 1);
                    end else begin
                        exp_mod = launch_q.pop_front();
                        chk("launch_mod", int'(core_mod_idx), int'(exp_mod));
                    end
                    launch_mod = core_mod_idx;
                    job_active = 1'b1;
                    mod_moved  = 1'b0;
                end else if (job_active && (core_mod_idx != launch_mod)) begin
                    mod_moved = 1'b1;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_tag", int'(rsp_tag), int'(e[3:0]));
                        chk("rsp_error", int'(rsp_error), int'(e[4]));
                    end
                    if (job_active) begin
                        chk("mod_stable", int'(mod_moved), 0);
                    end
                    job_active = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [3:0] tag, input logic [5:0] mod, input logic err);
        int n = 0;
        cmd_valid   = 1'b1;
        cmd_tag     = tag;
        cmd_mod_idx = mod;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_timeout", int'(n < 500), 1);
        exp_q.push_back({err, tag});
        if (!err) launch_q.push_back(mod);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, int'(n < 3000), 1);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!core_start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, int'(core_start), 1);
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Release a held-low core: done rises, the head is popped, LAUNCH follows.
    task automatic release_core(input string name);
        core_manual_level = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk(name, int'(core_start), 1);
        core_manual = 1'b0;
    endtask

    initial begin
        int s0;
        int c0;
        int n;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_mod_idx = 6'd0;
        cmd_tag     = 4'd0;
        rsp_ready   = 1'b1;
        cycles(3);
        reset = 1'b0;

        // Reset state
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_core_start", int'(core_start), 0);
        chk("rst_core_mod_idx", int'(core_mod_idx), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(jobs_done_count), 0);

        // Single job: mod 5, tag 3
        drop_delay = 2;
        run_len    = 100;
        push(4'd3, 6'd5, 1'b0);
        wait_idle("single_idle");
        chk("single_count", int'(jobs_done_count), 1);
        chk("single_starts", start_count, 1);

        // FIFO fill with a stalled core
        run_len     = 5;
        core_manual = 1'b1;
        core_manual_level = 1'b0;
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            push(4'(i), 6'(i + 1), 1'b0);
        end
        chk("full_cmd_ready", int'(cmd_ready), 0);
        chk("full_busy", int'(busy), 1);
        release_core("full_first_launch");
        chk("full_ready_after_pop", int'(cmd_ready), 1);
        wait_idle("full_idle");
        chk("full_count", int'(jobs_done_count), 5);

        // Range boundary: 60 and 63 rejected, 59 accepted
        s0 = start_count;
        c0 = int'(jobs_done_count);
        push(4'd9, 6'd60, 1'b1);
        push(4'd10, 6'd63, 1'b1);
        push(4'd11, 6'd59, 1'b0);
        wait_idle("range_idle");
        chk("range_count", int'(jobs_done_count), c0 + 1);
        chk("range_starts", start_count, s0 + 1);

        // Response back-pressure: hold rsp_ready low 10 cycles
        rsp_ready = 1'b0;
        push(4'd7, 6'd10, 1'b0);
        push(4'd8, 6'd11, 1'b0);
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_rsp_seen", int'(rsp_valid), 1);
        s0 = start_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", int'(rsp_valid), 1);
            chk("hold_rsp_tag", int'(rsp_tag), 7);
            chk("hold_no_start", start_count, s0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle("hold_idle");

        // Reset in RUN with two jobs queued
        run_len = 200;
        push(4'd1, 6'd2, 1'b0);
        wait_start("rst_job_start");
        push(4'd4, 6'd3, 1'b0);
        push(4'd5, 6'd4, 1'b0);
        cycles(10);
        reset = 1'b1;
        exp_q.delete();
        launch_q.delete();
        core_manual       = 1'b1;
        core_manual_level = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_cmd_ready", int'(cmd_ready), 1);
        chk("midrst_core_start", int'(core_start), 0);
        chk("midrst_core_mod_idx", int'(core_mod_idx), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_rsp_tag", int'(rsp_tag), 0);
        chk("midrst_rsp_error", int'(rsp_error), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(jobs_done_count), 0);
        run_len = 5;
        s0 = start_count;
        push(4'd6, 6'd7, 1'b0);
        cycles(5);
        chk("midrst_wait_done", start_count, s0);
        release_core("midrst_launch");
        wait_idle("midrst_idle");
        chk("midrst_count_after", int'(jobs_done_count), 1);

`ifdef NTT_JOB_SEQUENCER_TIMEOUT_EN
        // Watchdog: core never acknowledges completion
        c0 = int'(jobs_done_count);
        core_manual       = 1'b1;
        core_manual_level = 1'b1;
        push(4'd12, 6'd8, 1'b1);
        launch_q.push_back(6'd8);
        wait_start("to_start");
        core_manual_level = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_latency_lo", int'(n >= 49), 1);
        chk("to_latency_hi", int'(n <= 52), 1);
        wait_idle("to_idle");
        chk("to_count", int'(jobs_done_count), c0);
        s0 = start_count;
        push(4'd13, 6'd9, 1'b0);
        cycles(10);
        chk("to_wait_done", start_count, s0);
        release_core("to_relaunch");
        wait_idle("to_relaunch_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
